// File: rtl/pulse_analyzer.sv
// pulse_analyzer: synchronises an asynchronous pulse train, detects its edges,
// measures high width and period in clock cycles, counts pulses and flags a
// stuck or absent train.
module pulse_analyzer #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic [15:0]      pulse_count,
    output logic             stuck,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]      TIMER_END  = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    // Registered state
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    logic                   edge_rise_q, edge_rise_d;
    logic                   edge_fall_q, edge_fall_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hl_int_q, hl_int_d;
    logic [CNT_W-1:0]       high_len_q, high_len_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic [15:0]            pulse_count_q, pulse_count_d;
    logic [15:0]            timer_q, timer_d;
    logic                   stuck_q, stuck_d;
    logic                   overflow_q, overflow_d;

    // Combinational helpers
    logic                   s_sync_s;
    logic                   any_edge_s;
    logic                   timeout_s;
    logic                   cnt_sat_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic [CNT_W:0]         sum_s;
    logic [CNT_W-1:0]       period_sat_s;

    assign s_sync_s     = sync_q[SYNC_STAGES-1];
    assign any_edge_s   = edge_rise_q | edge_fall_q;
    // An edge in the same cycle always beats the timeout.
    assign timeout_s    = enable & ~any_edge_s & (timer_q == TIMER_LAST);
    assign cnt_sat_s    = (cnt_q == CNT_MAX);
    assign cnt_next_s   = cnt_sat_s ? cnt_q : (cnt_q + CNT_ONE);
    // Period sum is one bit wider so a carry out can be caught and clamped.
    assign sum_s        = {1'b0, hl_int_q} + {1'b0, cnt_q};
    assign period_sat_s = sum_s[CNT_W] ? CNT_MAX : sum_s[CNT_W-1:0];

    // Synchroniser shift, previous-sample tap and edge strobes (run regardless of enable).
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], signal};
        s_prev_d    = s_sync_s;
        edge_rise_d = s_sync_s & ~s_prev_q;
        edge_fall_d = ~s_sync_s & s_prev_q;
    end

    // Idle timer and stuck flag: cleared by any edge or by disabling.
    always_comb begin
        timer_d = timer_q;
        stuck_d = stuck_q;
        if (!enable) begin
            timer_d = 16'd0;
            stuck_d = 1'b0;
        end else if (any_edge_s) begin
            timer_d = 16'd0;
            stuck_d = 1'b0;
        end else if (timer_q < TIMER_END) begin
            timer_d = timer_q + 16'd1;
            if (timeout_s) begin
                stuck_d = 1'b1;
            end else begin
                stuck_d = stuck_q;
            end
        end else begin
            timer_d = timer_q;
            stuck_d = stuck_q;
        end
    end

    // Pulse counter: rising edges while enabled and out of IDLE, wrapping freely.
    always_comb begin
        if (enable && (state_q != ST_IDLE) && edge_rise_q) begin
            pulse_count_d = pulse_count_q + 16'd1;
        end else begin
            pulse_count_d = pulse_count_q;
        end
    end

    // Measurement FSM: next state, cycle counter, captured widths and overflow.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hl_int_d     = hl_int_q;
        high_len_d   = high_len_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        overflow_d   = overflow_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (timeout_s) begin
            state_d = ST_ARM;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ZERO;
                end
                ST_ARM: begin
                    if (edge_rise_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (edge_fall_q) begin
                        hl_int_d = cnt_q;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_LOW;
                    end else begin
                        cnt_d = cnt_next_s;
                        if (cnt_sat_s) begin
                            overflow_d = 1'b1;
                        end else begin
                            overflow_d = overflow_q;
                        end
                    end
                end
                ST_LOW: begin
                    if (edge_rise_q) begin
                        high_len_d   = hl_int_q;
                        period_d     = period_sat_s;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_ONE;
                        state_d      = ST_HIGH;
                        if (sum_s[CNT_W]) begin
                            overflow_d = 1'b1;
                        end else begin
                            overflow_d = overflow_q;
                        end
                    end else begin
                        cnt_d = cnt_next_s;
                        if (cnt_sat_s) begin
                            overflow_d = 1'b1;
                        end else begin
                            overflow_d = overflow_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State register with synchronous active-high reset clearing everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= {SYNC_STAGES{1'b0}};
            s_prev_q      <= 1'b0;
            edge_rise_q   <= 1'b0;
            edge_fall_q   <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            hl_int_q      <= CNT_ZERO;
            high_len_q    <= CNT_ZERO;
            period_q      <= CNT_ZERO;
            meas_valid_q  <= 1'b0;
            pulse_count_q <= 16'd0;
            timer_q       <= 16'd0;
            stuck_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            s_prev_q      <= s_prev_d;
            edge_rise_q   <= edge_rise_d;
            edge_fall_q   <= edge_fall_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hl_int_q      <= hl_int_d;
            high_len_q    <= high_len_d;
            period_q      <= period_d;
            meas_valid_q  <= meas_valid_d;
            pulse_count_q <= pulse_count_d;
            timer_q       <= timer_d;
            stuck_q       <= stuck_d;
            overflow_q    <= overflow_d;
        end
    end

    assign edge_rise   = edge_rise_q;
    assign edge_fall   = edge_fall_q;
    assign high_len    = high_len_q;
    assign period      = period_q;
    assign meas_valid  = meas_valid_q;
    assign pulse_count = pulse_count_q;
    assign stuck       = stuck_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Bench for pulse_analyzer: randomised pulse trains checked every cycle against
// a timestamp-based reference model, plus a counter-saturation scenario on a
// second instance with a long timeout.
module tb_pulse_analyzer;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 200;
    localparam int TMO_B = 1000;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, enable, sig;

    logic             er, ef, mv, stk, ovf;
    logic [CNT_W-1:0] hl, per;
    logic [15:0]      pc;

    logic             b_er, b_ef, b_mv, b_stk, b_ovf;
    logic [CNT_W-1:0] b_hl, b_per;
    logic [15:0]      b_pc;

    pulse_analyzer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .signal(sig),
        .edge_rise(er), .edge_fall(ef), .high_len(hl), .period(per),
        .meas_valid(mv), .pulse_count(pc), .stuck(stk), .overflow(ovf)
    );

    pulse_analyzer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO_B)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .signal(sig),
        .edge_rise(b_er), .edge_fall(b_ef), .high_len(b_hl), .period(b_per),
        .meas_valid(b_mv), .pulse_count(b_pc), .stuck(b_stk), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 disabled, 1 waiting for first rise, 2 measuring high, 3 measuring low.
    int k = 0;
    int phase = 0;
    int t_start = 0;
    int last_edge = 0;
    int m_hl_int = 0, m_hl = 0, m_per = 0, m_pc = 0;
    bit m_mv = 0, m_stk = 0, m_ov = 0, m_er = 0, m_ef = 0;
    bit hist [0:SYNC+1];

    // Model update on each clock edge, then compare all outputs shortly after.
    always @(posedge clk) begin
        bit rs, fs, tmo;
        int d, s;
        k++;
        rs = m_er;
        fs = m_ef;
        m_mv = 1'b0;
        if (reset) begin
            phase = 0; m_hl_int = 0; m_hl = 0; m_per = 0; m_pc = 0;
            m_stk = 0; m_ov = 0; m_er = 0; m_ef = 0; last_edge = k;
            for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
        end else begin
            for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sig;
            m_er = hist[SYNC] & ~hist[SYNC+1];
            m_ef = ~hist[SYNC] & hist[SYNC+1];
            if (!enable) begin
                phase = 0;
                m_stk = 0;
                last_edge = k;
            end else begin
                tmo = 1'b0;
                if (rs || fs) begin
                    last_edge = k;
                    m_stk = 0;
                end else if (k - last_edge == TMO) begin
                    tmo = 1'b1;
                    m_stk = 1;
                end
                if (phase != 0 && rs) m_pc = (m_pc + 1) % 65536;
                if (tmo) begin
                    phase = 1;
                end else begin
                    d = k - t_start;
                    case (phase)
                        0: phase = 1;
                        1: if (rs) begin phase = 2; t_start = k; end
                        2: begin
                            if (fs) begin
                                m_hl_int = (d > MAXV) ? MAXV : d;
                                phase = 3;
                                t_start = k;
                            end else if (d >= MAXV) m_ov = 1;
                        end
                        default: begin
                            if (rs) begin
                                s = m_hl_int + ((d > MAXV) ? MAXV : d);
                                m_per = (s > MAXV) ? MAXV : s;
                                if (s > MAXV) m_ov = 1;
                                m_hl = m_hl_int;
                                m_mv = 1'b1;
                                phase = 2;
                                t_start = k;
                            end else if (d >= MAXV) m_ov = 1;
                        end
                    endcase
                end
            end
        end
        #1;
        check_val("edge_rise", er, m_er);
        check_val("edge_fall", ef, m_ef);
        check_val("meas_valid", mv, m_mv);
        check_val("high_len", hl, m_hl);
        check_val("period", per, m_per);
        check_val("pulse_count", pc, m_pc);
        check_val("stuck", stk, m_stk);
        check_val("overflow", ovf, m_ov);
    end

    // Capture measurements from the long-timeout instance.
    int bq_hl[$], bq_per[$], bq_ov[$];
    always @(posedge clk) begin
        #1;
        if (b_mv === 1'b1) begin
            bq_hl.push_back(int'(b_hl));
            bq_per.push_back(int'(b_per));
            bq_ov.push_back(int'(b_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig = lvl;
        end
    endtask

    task automatic square(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    int exp_hl[3]  = '{255, 3, 6 - 3};
    int exp_per[3] = '{255, 6, 6};

    initial begin
        reset = 1'b1; enable = 1'b0; sig = 1'b0;
        // reset with signal toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            sig = ~sig;
        end
        @(negedge clk); reset = 1'b0; sig = 1'b0;
        // disabled: strobes only
        square(4, 3, 3);
        // square wave 3/3
        @(negedge clk); enable = 1'b1;
        hold(1'b0, 4);
        square(10, 3, 3);
        // asymmetric duty 2/7
        square(8, 2, 7);
        // random widths
        for (int i = 0; i < 40; i++) square(1, $urandom_range(1, 20), $urandom_range(1, 20));
        // period-sum saturation
        square(1, 150, 150);
        square(1, 120, 140);
        for (int i = 0; i < 6; i++) square(1, $urandom_range(90, 190), $urandom_range(1, 190));
        square(3, 3, 3);
        // stuck low then recovery
        hold(1'b0, 250);
        square(4, 3, 3);
        // reset in the middle of a high phase
        hold(1'b1, 5);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        hold(1'b1, 3); hold(1'b0, 3);
        square(4, 3, 3);
        // enable dropped in the middle of a high phase
        hold(1'b1, 6);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        @(negedge clk); enable = 1'b1;
        hold(1'b1, 2); hold(1'b0, 3);
        square(4, 3, 3);
        // random enable gating
        for (int i = 0; i < 30; i++) begin
            enable = ($urandom_range(0, 4) != 0);
            square(1, $urandom_range(1, 12), $urandom_range(1, 12));
        end
        @(negedge clk); enable = 1'b1;
        // counter saturation on the long-timeout instance
        @(negedge clk); reset = 1'b1;
        bq_hl.delete(); bq_per.delete(); bq_ov.delete();
        @(negedge clk); reset = 1'b0;
        hold(1'b0, 10);
        hold(1'b1, 300); hold(1'b0, 4);
        square(3, 3, 3);
        hold(1'b0, 10);
        check_val("sat_meas_count", bq_hl.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < bq_hl.size()) begin
                check_val("sat_high_len", bq_hl[i], exp_hl[i]);
                check_val("sat_period", bq_per[i], exp_per[i]);
                check_val("sat_overflow", bq_ov[i], 1);
            end
        end
        @(negedge clk);
        check_val("sat_overflow_sticky", b_ovf, 1'b1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_val("sat_overflow_reset", b_ovf, 1'b0);
        check_val("sat_high_len_reset", b_hl, 0);
        check_val("sat_period_reset", b_per, 0);
        hold(1'b0, 5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
